// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
//   Bundles every handshake and bus signal around the shared memory port:
//   the I-cache fill port, the D-cache fill/write port, the DMA bus
//   request/grant pair and the memory read/write port.
//
//   master : the arbiter's view (drives completions, grant and memory side)
//   slave  : the environment's view (caches, DMA master and memory model)
//
//   Signals
//     i_req, i_addr        I-cache line fill request (level) and address
//     i_line, i_done       filled I line and its one-cycle completion pulse
//     d_rd_req, d_wr_req   D-cache line fill / write-through word requests
//     d_addr, d_wdata      D address and write word
//     d_line, d_done       filled D line and D completion pulse
//     dma_br, dma_bg       DMA bus request / bus grant
//     m_read, m_write      memory line read / word write strobes
//     m_addr, m_wdata      memory address and write data
//     m_rdata              memory line data
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [LINE_W-1:0]    i_line;
  logic                 i_done;

  logic                 d_rd_req;
  logic                 d_wr_req;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [LINE_W-1:0]    d_line;
  logic                 d_done;

  logic                 dma_br;
  logic                 dma_bg;

  logic                 m_read;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_addr;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [LINE_W-1:0]    m_rdata;

  modport master (
    input  i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, dma_br, m_rdata,
    output i_line, i_done, d_line, d_done, dma_bg,
           m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, dma_br, m_rdata,
    input  i_line, i_done, d_line, d_done, dma_bg,
           m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//   Sequences the single shared memory port between I-cache line fills,
//   D-cache line fills, D-cache write-through word writes and a DMA master.
//   One transaction is in flight at a time; every memory access takes a
//   fixed MEM_LATENCY cycles, followed by one DONE cycle carrying the
//   completion pulse. When both caches are waiting, the side that was not
//   served last wins; within the D side a write beats a read. DMA has the
//   highest priority but is only granted from IDLE.
//
//   Ports
//     clk      clock
//     reset_n  synchronous active-low reset; aborts any transaction
//     bus      cache_mem_arbiter_if.master (cache, DMA and memory signals)
//
//   Parameters
//     WORD_SIZE    data word and address width
//     LINE_WORDS   words per cache line (power of two)
//     MEM_LATENCY  cycles the memory strobe is held (>= 1)
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cache_mem_arbiter_if.master   bus
);

  localparam int LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int OFF_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  // Mask of the word-within-line offset bits; cleared for line reads.
  localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("cache_mem_arbiter: MEM_LATENCY must be at least 1");
    end
    if ((1 << OFF_W) != LINE_WORDS) begin : g_bad_line
      $error("cache_mem_arbiter: LINE_WORDS must be a power of two");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2,
    DMA  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;   // 1: D side was served most recently
  logic             cur_d;    // granted side of the transaction in flight
  logic             cur_wr;   // transaction in flight is a D word write

  // -------------------------------------------------------------------------
  // Grant selection (evaluated in IDLE only)
  // -------------------------------------------------------------------------
  logic d_pend;
  logic pick_any;
  logic pick_d;
  logic pick_wr;
  logic [WORD_SIZE-1:0] pick_addr;

  assign d_pend = bus.d_rd_req | bus.d_wr_req;

  always_comb begin
    pick_any = 1'b0;
    pick_d   = 1'b0;
    if (bus.i_req && d_pend) begin
      pick_any = 1'b1;
      pick_d   = ~last_d;
    end else if (bus.i_req) begin
      pick_any = 1'b1;
      pick_d   = 1'b0;
    end else if (d_pend) begin
      pick_any = 1'b1;
      pick_d   = 1'b1;
    end
  end

  assign pick_wr   = pick_d & bus.d_wr_req;
  assign pick_addr = pick_d ? bus.d_addr : bus.i_addr;

  // -------------------------------------------------------------------------
  // Sequencer: all outputs are registered here
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_d      <= 1'b1;
      cur_d       <= 1'b0;
      cur_wr      <= 1'b0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.dma_bg  <= 1'b0;
      bus.m_read  <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_line  <= '0;
      bus.d_line  <= '0;
    end else begin
      // Completion pulses last a single cycle unless set again below.
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.dma_br) begin
            state       <= DMA;
            bus.dma_bg  <= 1'b1;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
          end else if (pick_any) begin
            state  <= MEM;
            cnt    <= '0;
            last_d <= pick_d;
            cur_d  <= pick_d;
            cur_wr <= pick_wr;
            // Address and data are latched here so requester changes
            // during the memory window have no effect.
            if (pick_wr) begin
              bus.m_write <= 1'b1;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
            end else begin
              bus.m_read  <= 1'b1;
              bus.m_addr  <= pick_addr & ~OFF_MASK;
              bus.m_wdata <= '0;
            end
          end
        end

        MEM: begin
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            cnt         <= '0;
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            // Memory data is valid at the end of the last strobe cycle.
            if (!cur_wr) begin
              if (cur_d) bus.d_line <= bus.m_rdata;
              else       bus.i_line <= bus.m_rdata;
            end
            if (cur_d) bus.d_done <= 1'b1;
            else       bus.i_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // No grant is made here so a requester that drops its request in
        // response to done is never served twice.
        DONE: begin
          state <= IDLE;
        end

        DMA: begin
          if (!bus.dma_br) begin
            state      <= IDLE;
            bus.dma_bg <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//   Scoreboard bench for cache_mem_arbiter (WORD_SIZE=16, LINE_WORDS=4,
//   MEM_LATENCY=4). Each scenario pushes the transactions it expects (side,
//   kind, memory address, write data and grant cycle) when it drives the
//   requests; a monitor pops them as the arbiter strobes memory and pulses
//   done. The memory model returns a line that depends on both the address
//   and the current cycle, so the captured line also pins the sample cycle.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int WS  = 16;
  localparam int LW  = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  cache_mem_arbiter_if #(.WORD_SIZE(WS), .LINE_WORDS(LW)) bus ();

  cache_mem_arbiter #(
    .WORD_SIZE  (WS),
    .LINE_WORDS (LW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mdata(input logic [15:0] a, input int c);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = (a ^ 16'(c * 37)) + 16'(k);
    return r;
  endfunction

  assign bus.m_rdata = mdata(bus.m_addr, cyc);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  typedef struct {
    logic        side_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          grant;
  } exp_t;

  exp_t        exp_q[$];
  int          mem_cnt = 0;
  logic        mon_en = 1'b1;
  logic [63:0] exp_i_line = '0;

  task automatic push(input logic side_d, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input int grant);
    exp_t e;
    e.side_d = side_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.grant = grant;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.m_read || bus.m_write) begin
        if (exp_q.size() == 0) begin
          check("spurious_mem", 64'(1), 64'(0));
        end else begin
          e = exp_q[0];
          if (mem_cnt == 0) check("mem_start_cyc", 64'(cyc), 64'(e.grant + 1));
          check("m_write", 64'(bus.m_write), 64'(e.wr));
          check("m_read", 64'(bus.m_read), 64'(!e.wr));
          check("m_addr", 64'(bus.m_addr), 64'(e.addr));
          if (e.wr) check("m_wdata", 64'(bus.m_wdata), 64'(e.wdata));
          mem_cnt++;
        end
      end
      if (bus.i_done || bus.d_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_side", 64'(bus.d_done), 64'(e.side_d));
          check("done_both", 64'(bus.i_done & bus.d_done), 64'(0));
          check("done_cyc", 64'(cyc), 64'(e.grant + LAT + 1));
          check("mem_len", 64'(mem_cnt), 64'(LAT));
          if (!e.wr) begin
            if (e.side_d) check("d_line", bus.d_line, mdata(e.addr, e.grant + LAT));
            else begin
              check("i_line", bus.i_line, mdata(e.addr, e.grant + LAT));
              exp_i_line = mdata(e.addr, e.grant + LAT);
            end
          end
          mem_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic samp(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_done(input logic side_d, input int limit);
    logic seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      seen = side_d ? bus.d_done : bus.i_done;
    end
    if (!seen) check(side_d ? "wait_d_done" : "wait_i_done", 64'(0), 64'(1));
  endtask

  task automatic check_outs_zero(input string pfx);
    check({pfx, "_ctrl"}, 64'({bus.i_done, bus.d_done, bus.dma_bg, bus.m_read, bus.m_write}), 64'(0));
    check({pfx, "_m_addr"}, 64'(bus.m_addr), 64'(0));
    check({pfx, "_m_wdata"}, 64'(bus.m_wdata), 64'(0));
    check({pfx, "_i_line"}, bus.i_line, 64'(0));
    check({pfx, "_d_line"}, bus.d_line, 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n      = 1'b0;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_rd_req = 1'b0;
    bus.d_wr_req = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.dma_br   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    step();
    reset_n = 1'b1;

    // Contention right after reset: last served is D, so I goes first
    step();
    t = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h0104;
    bus.d_rd_req = 1'b1; bus.d_addr = 16'h0209;
    push(1'b0, 1'b0, 16'h0104, 16'h0, t);
    push(1'b1, 1'b0, 16'h0208, 16'h0, t + 6);
    wait_done(1'b0, 20);
    step(); bus.i_req = 1'b0;
    wait_done(1'b1, 20);
    step(); bus.d_rd_req = 1'b0;

    // Single I fill; address change mid-window must not matter
    step();
    t = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    push(1'b0, 1'b0, 16'h1234, 16'h0, t);
    go(t + 2); bus.i_addr = 16'hFFF0;
    wait_done(1'b0, 20);
    step(); bus.i_req = 1'b0;

    // D write beats D read; write data change mid-window has no effect
    step();
    t = cyc;
    bus.d_wr_req = 1'b1; bus.d_rd_req = 1'b1;
    bus.d_addr = 16'h0042; bus.d_wdata = 16'hBEEF;
    push(1'b1, 1'b1, 16'h0042, 16'hBEEF, t);
    push(1'b1, 1'b0, 16'h0040, 16'h0, t + 6);
    go(t + 2); bus.d_wdata = 16'h0000;
    wait_done(1'b1, 20);
    step(); bus.d_wr_req = 1'b0;
    wait_done(1'b1, 20);
    step(); bus.d_rd_req = 1'b0;
    check("i_line_hold", bus.i_line, exp_i_line);

    // Fairness: both sides held, grants alternate I, D, I, D
    step();
    t = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h0A00;
    bus.d_rd_req = 1'b1; bus.d_addr = 16'h0B04;
    push(1'b0, 1'b0, 16'h0A00, 16'h0, t);
    push(1'b1, 1'b0, 16'h0B04, 16'h0, t + 6);
    push(1'b0, 1'b0, 16'h0A00, 16'h0, t + 12);
    push(1'b1, 1'b0, 16'h0B04, 16'h0, t + 18);
    wait_done(1'b0, 20);
    wait_done(1'b1, 20);
    wait_done(1'b0, 20);
    wait_done(1'b1, 20);
    step(); bus.i_req = 1'b0; bus.d_rd_req = 1'b0;

    // DMA requested during an I fill: granted only after DONE
    step();
    t = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h2000;
    push(1'b0, 1'b0, 16'h2000, 16'h0, t);
    go(t + 2); bus.dma_br = 1'b1;
    for (int c = t + 2; c <= t + 5; c++) begin
      samp(c);
      check("dma_bg_wait", 64'(bus.dma_bg), 64'(0));
    end
    step(); bus.i_req = 1'b0;
    samp(t + 6);
    check("dma_bg_wait", 64'(bus.dma_bg), 64'(0));
    samp(t + 7);
    check("dma_bg_on", 64'(bus.dma_bg), 64'(1));
    check("dma_m_addr", 64'(bus.m_addr), 64'(0));
    go(t + 8); bus.i_req = 1'b1; bus.i_addr = 16'h3004;
    push(1'b0, 1'b0, 16'h3004, 16'h0, t + 13);
    go(t + 12); bus.dma_br = 1'b0;
    samp(t + 12);
    check("dma_bg_held", 64'(bus.dma_bg), 64'(1));
    samp(t + 13);
    check("dma_bg_off", 64'(bus.dma_bg), 64'(0));
    wait_done(1'b0, 20);
    step(); bus.i_req = 1'b0;

    // Reset in the middle of a fill aborts it without a done pulse
    step();
    t = cyc;
    mon_en = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h4000;
    samp(t + 1);
    check("abort_m_read", 64'(bus.m_read), 64'(1));
    check("abort_m_addr", 64'(bus.m_addr), 64'(16'h4000));
    go(t + 2); reset_n = 1'b0; bus.i_req = 1'b0;
    samp(t + 3);
    check_outs_zero("abort");
    go(t + 4); reset_n = 1'b1; mon_en = 1'b1;
    go(t + 5); bus.i_req = 1'b1; bus.i_addr = 16'h5008;
    push(1'b0, 1'b0, 16'h5008, 16'h0, t + 5);
    wait_done(1'b0, 20);
    step(); bus.i_req = 1'b0;

    repeat (8) step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences the single shared memory port between I-cache line fills, D-cache line fills, D-cache write-through word writes, and a DMA master.
- Sits between the I/D caches and the memory model; owns the memory address/control lines and the DMA bus-request/grant handshake.
- Services exactly one transaction at a time with a fixed memory latency.
- Fairness between the I and D sides is provided by a last-served toggle.

Parameters:
- WORD_SIZE, 16, data word and address width.
- LINE_WORDS, 4, words per cache line; line width = WORD_SIZE*LINE_WORDS.
- MEM_LATENCY, 4, cycles m_read/m_write is held before data/write completes (>=1).

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset.
- i_req  input  1  I-cache line-fill request; level, held until i_done.
- i_addr  input  WORD_SIZE  I fill address; low log2(LINE_WORDS) bits ignored.
- i_line  output  WORD_SIZE*LINE_WORDS  filled line; valid in the i_done cycle.
- i_done  output  1  one-cycle completion pulse for I.
- d_rd_req  input  1  D-cache line-fill request; level.
- d_wr_req  input  1  D write-through word request; level.
- d_addr  input  WORD_SIZE  D address.
- d_wdata  input  WORD_SIZE  D write word.
- d_line  output  WORD_SIZE*LINE_WORDS  filled D line; valid in the d_done cycle.
- d_done  output  1  one-cycle completion pulse for D (read or write).
- dma_br  input  1  DMA bus request; level.
- dma_bg  output  1  DMA bus grant.
- m_read  output  1  memory line read.
- m_write  output  1  memory word write.
- m_addr  output  WORD_SIZE  memory address; line-aligned for reads.
- m_wdata  output  WORD_SIZE  memory write data.
- m_rdata  input  WORD_SIZE*LINE_WORDS  memory line data; sampled at the end of the last MEM cycle.

Behaviour:
- Reset:
  - State IDLE, latency counter 0, last_served = D.
  - All outputs 0: i_done, d_done, dma_bg, m_read, m_write, m_addr, m_wdata, i_line, d_line.
  - Reset mid-transaction aborts it with no done pulse.
- States: IDLE, MEM, DONE, DMA.
- IDLE selection priority:
  1. dma_br -> DMA. dma_bg=1 from the next cycle.
  2. Cache requests:
     - If only one side is pending, grant it.
     - If both I and D are pending, grant the side opposite to last_served.
     - Within D, d_wr_req beats d_rd_req.
  3. Nothing pending -> stay in IDLE.
- Grant (cycle T, state IDLE):
  - Latch kind, side and address.
  - Enter MEM at T+1.
  - Update last_served.
- MEM:
  - m_read or m_write held high for exactly MEM_LATENCY cycles (T+1..T+MEM_LATENCY).
  - m_addr/m_wdata held constant for the whole window.
  - Read address = addr with the low line-offset bits zeroed.
  - Counter counts 0..MEM_LATENCY-1; on the last count, a read captures m_rdata into the requester's line register.
- DONE (T+MEM_LATENCY+1):
  - m_read/m_write low; the granted side's done pulses for 1 cycle with its line valid.
  - No new grant in DONE, so a requester dropping req after done is never re-served.
  - Next state IDLE.
- Latency: request acceptance to done = MEM_LATENCY+1 cycles. Back-to-back grant spacing = MEM_LATENCY+2.
- i_line/d_line hold their value until the next fill on that side.
- DMA: dma_br is never granted mid-transaction; it waits for IDLE.
  - While in DMA: dma_bg=1, m_read=m_write=0, m_addr=0, cache requests stall.
  - dma_br deasserted -> dma_bg=0 the next cycle, then return to IDLE. Cache grant is possible the cycle after that.
- Request dropped while in MEM: the transaction still completes and the done pulse is still issued; the requester ignores it.
- Address change during MEM has no effect, because the address is latched.
- Simultaneous d_rd_req and d_wr_req: the write is served first; the read is served on a later grant.

Test Plan:
- Single I fill, MEM_LATENCY=4:
  - Stimulus: i_req at cycle 0, i_addr=0x1236.
  - Required: m_read cycles 1-4 with m_addr=0x1234; i_done at cycle 5 with i_line = the m_rdata value sampled in cycle 4.
- Contention: i_req and d_rd_req both asserted at cycle 0 after reset (last_served=D).
  - Required: I is granted first; D is granted at cycle 6; d_done at cycle 11.
- Write priority: d_wr_req with d_addr=0x0042, d_wdata=0xBEEF, plus d_rd_req, both held.
  - Required: m_write cycles 1-4 with 0x0042/0xBEEF; d_done at 5; then the read is served.
- DMA:
  - Stimulus: dma_br raised during an I fill.
  - Required: dma_bg rises only after the DONE cycle. An i_req raised while granted is not served until 2 cycles after dma_br drops.
- Reset mid-MEM:
  - Stimulus: reset_n low at cycle 2 of a fill.
  - Required: next cycle all outputs are 0, no done pulse, and IDLE accepts a fresh request after reset_n rises.
- Fairness: i_req and d_rd_req both held continuously.
  - Required: grants alternate I, D, I, D with done pulses every 6 cycles.
